// File: rtl/debounce_multi_channel.sv
// N-channel switch debouncer: two-flop synchroniser, stability counter,
// registered rise/fall strobes and a per-channel toggle state.
module debounce_multi_channel #(
  parameter int NUM_CH            = 4,
  parameter int DEBOUNCE_LIMIT    = 250000,
  parameter bit RESET_LEVEL       = 1'b0,
  parameter bit TOGGLE_ON_RELEASE = 1'b1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Bouncy,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Toggle
);

  localparam int              CW   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0] sync_p0;
  logic [NUM_CH-1:0] sync_p1;
  logic [CW-1:0]     count_p2 [NUM_CH];

  // stage p0/p1: metastability synchroniser on the raw pins
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_p0 <= {NUM_CH{RESET_LEVEL}};
      sync_p1 <= {NUM_CH{RESET_LEVEL}};
    end else begin
      sync_p0 <= i_Bouncy;
      sync_p1 <= sync_p0;
    end
  end

  // stage p2: stability counter, level update, strobes and toggle
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        count_p2[ch] <= '0;
      end
      o_Debounced <= {NUM_CH{RESET_LEVEL}};
      o_Rise      <= '0;
      o_Fall      <= '0;
      o_Toggle    <= '0;
    end else begin
      o_Rise <= '0;
      o_Fall <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (sync_p1[ch] == o_Debounced[ch]) begin
          count_p2[ch] <= '0;
        end else if (count_p2[ch] == LAST) begin
          count_p2[ch]    <= '0;
          o_Debounced[ch] <= sync_p1[ch];
          o_Rise[ch]      <= sync_p1[ch];
          o_Fall[ch]      <= ~sync_p1[ch];
          if (sync_p1[ch] != TOGGLE_ON_RELEASE) begin
            o_Toggle[ch] <= ~o_Toggle[ch];
          end
        end else begin
          count_p2[ch] <= count_p2[ch] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_multi_channel.sv
// Directed bench for debounce_multi_channel (4 channels, limit 4) with a
// per-cycle scoreboard fed by a run-length reference model.
module tb_debounce_multi_channel;

  localparam int LIMIT = 4;
  localparam bit RLVL  = 1'b0;
  localparam bit TOR   = 1'b1;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] bouncy;
  logic [3:0] deb, rise, fall, tog;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] tog;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_s0, m_s1, m_deb, m_rise, m_fall, m_tog;
  int         m_run [4];

  debounce_multi_channel #(
    .NUM_CH(4), .DEBOUNCE_LIMIT(LIMIT), .RESET_LEVEL(RLVL), .TOGGLE_ON_RELEASE(TOR)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Bouncy(bouncy),
    .o_Debounced(deb), .o_Rise(rise), .o_Fall(fall), .o_Toggle(tog)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s0 = {4{RLVL}}; m_s1 = {4{RLVL}}; m_deb = {4{RLVL}};
    m_rise = '0; m_fall = '0; m_tog = '0;
    for (int c = 0; c < 4; c++) m_run[c] = 0;
  endtask

  // Level changes once the synchronised value has differed from the
  // current level for LIMIT consecutive samples.
  task automatic model_edge();
    for (int c = 0; c < 4; c++) begin
      logic upd;
      upd = (m_s1[c] != m_deb[c]) && (m_run[c] >= LIMIT);
      m_rise[c] = upd && m_s1[c];
      m_fall[c] = upd && !m_s1[c];
      if (upd) begin
        m_deb[c] = m_s1[c];
        if (m_s1[c] == !TOR) m_tog[c] = ~m_tog[c];
      end
      if (m_s0[c] == m_s1[c]) m_run[c] = (m_run[c] < LIMIT) ? m_run[c] + 1 : m_run[c];
      else m_run[c] = 1;
      m_s1[c] = m_s0[c];
      m_s0[c] = bouncy[c];
    end
  endtask

  task automatic tick(input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    bouncy = b;
    if (rst_l) model_edge();
    else model_reset();
    e.deb = m_deb; e.rise = m_rise; e.fall = m_fall; e.tog = m_tog;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_deb", deb, e.deb);
    check("sb_rise", rise, e.rise);
    check("sb_fall", fall, e.fall);
    check("sb_tog", tog, e.tog);
  endtask

  initial begin
    int edge_n, nr, nf, ri, nfall;
    logic [3:0] acc, first_val;
    int bpat [6] = '{1, 0, 1, 1, 0, 1};

    // 1: reset with ch0 held high, then latency of 6 edges
    bouncy = 4'b0001;
    rst_l  = 1'b1;
    #2 rst_l = 1'b0;
    model_reset();
    #1;
    check("t1_rst_deb", deb, 4'h0);
    check("t1_rst_tog", tog, 4'h0);
    for (int i = 0; i < 3; i++) tick(4'b0001);
    check("t1_rst_hold_deb", deb, 4'h0);
    rst_l = 1'b1;
    edge_n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(4'b0001);
      if (deb[0] && edge_n == 0) begin
        edge_n = i;
        check("t1_rise_strobe", rise, 4'b0001);
      end
      if (i == 7) check("t1_rise_clear", rise, 4'b0000);
    end
    check_int("t1_latency", edge_n, 6);

    // 2: bounce on ch1
    nr = 0; nf = 0; ri = 0;
    for (int i = 0; i < 14; i++) begin
      tick({2'b00, (i < 6) ? bpat[i][0] : 1'b1, 1'b1});
      if (rise[1]) begin nr++; ri = i + 1; end
      if (fall[1]) nf++;
    end
    check_int("t2_rise_count", nr, 1);
    check_int("t2_fall_count", nf, 0);
    check_int("t2_rise_edge", ri, 11);
    check("t2_level", 4'(deb[1]), 4'h1);

    // 3: two press/release cycles on ch2, toggle on release
    for (int rep = 0; rep < 2; rep++) begin
      nfall = 0;
      for (int i = 0; i < 40; i++) begin
        tick({1'b0, (i < 20), 2'b11});
        if (rise[2]) check("t3_tog_at_rise", 4'(tog[2]), 4'(rep == 1));
        if (fall[2]) begin
          nfall++;
          check("t3_tog_at_fall", 4'(tog[2]), 4'(rep == 0));
        end
      end
      check_int("t3_fall_count", nfall, 1);
    end

    // 4: 3-cycle pulse on ch3 is filtered out
    acc = '0;
    for (int i = 0; i < 13; i++) begin
      tick({(i < 3), 3'b011});
      acc |= {deb[3], rise[3], fall[3], tog[3]};
    end
    check("t4_no_activity", acc, 4'h0);

    // 5: all channels rise together
    for (int i = 0; i < 10; i++) tick(4'b0000);
    edge_n = 0; first_val = '0;
    for (int i = 1; i <= 8; i++) begin
      tick(4'b1111);
      if (rise != 4'h0 && edge_n == 0) begin edge_n = i; first_val = rise; end
      if (i == 7) check("t5_rise_clear", rise, 4'h0);
    end
    check_int("t5_rise_edge", edge_n, 6);
    check("t5_rise_all", first_val, 4'hF);

    // 6a: async reset while ch0 counter is at 2 and its toggle is set
    for (int i = 0; i < 4; i++) tick(4'b1110);
    check("t6_deb_before", deb, 4'hF);
    check("t6_tog0_before", 4'(tog[0]), 4'h1);
    #2 rst_l = 1'b0;
    model_reset();
    #1;
    check("t6_async_deb", deb, 4'h0);
    check("t6_async_tog", tog, 4'h0);
    check("t6_async_rise", rise, 4'h0);
    check("t6_async_fall", fall, 4'h0);
    tick(4'b1111);
    rst_l = 1'b1;

    // 6b: press/release all, then async reset with toggles set
    for (int i = 0; i < 8; i++) tick(4'b1111);
    for (int i = 0; i < 8; i++) tick(4'b0000);
    check("t6_tog_set", tog, 4'hF);
    #2 rst_l = 1'b0;
    model_reset();
    #1;
    check("t6_async_tog2", tog, 4'h0);
    check("t6_async_deb2", deb, 4'h0);
    tick(4'b0000);
    rst_l = 1'b1;
    tick(4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi_channel.md
Name: debounce_multi_channel

Overview:
Parametrised N-channel debounce filter for mechanical switch inputs, with built-in edge detection and per-channel toggle state. Each channel synchronises its raw input, requires it to be stable for DEBOUNCE_LIMIT clocks, then updates a clean level. It also emits single-cycle rise/fall strobes and a toggle output. The block sits between board switch pins and user logic and replaces per-switch debounce-plus-toggle instance pairs.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
DEBOUNCE_LIMIT, 250000, clocks an input must be stable before the debounced level changes (>=1; 250000 = 10 ms at 25 MHz)
RESET_LEVEL, 0, reset value of synchroniser flops and debounced level, all channels
TOGGLE_ON_RELEASE, 1, 1: o_Toggle flips on debounced falling edge; 0: flips on rising edge

Ports:
i_Clk  input  1  system clock
i_Rst_L  input  1  asynchronous reset, active low
i_Bouncy  input  NUM_CH  raw switch inputs, asynchronous to i_Clk
o_Debounced  output  NUM_CH  filtered level per channel
o_Rise  output  NUM_CH  1-cycle strobe when o_Debounced[n] goes 0->1
o_Fall  output  NUM_CH  1-cycle strobe when o_Debounced[n] goes 1->0
o_Toggle  output  NUM_CH  per-channel toggle state (e.g. LED drive)

Behaviour:
- Reset (i_Rst_L=0, asynchronous, any time incl. mid-count): sync flops = RESET_LEVEL; counters = 0; o_Debounced = RESET_LEVEL; o_Rise = o_Fall = 0; o_Toggle = 0. Reset deassertion is used as-is; the board reset is already synchronised upstream.
- Synchroniser: 2 flops per channel on i_Bouncy; the second stage is s[n]. Logic never uses raw i_Bouncy.
- Counter: per channel, width $clog2(DEBOUNCE_LIMIT+1), unsigned.
  - If s[n] != o_Debounced[n] and count < DEBOUNCE_LIMIT-1: count <= count+1.
  - If s[n] != o_Debounced[n] and count == DEBOUNCE_LIMIT-1: o_Debounced[n] <= s[n]; count <= 0.
  - If s[n] == o_Debounced[n]: count <= 0. Any glitch back to the current level restarts the count.
  - The counter never exceeds DEBOUNCE_LIMIT-1 and never wraps.
- Latency: a clean step on i_Bouncy[n] reaches o_Debounced[n] on the (DEBOUNCE_LIMIT+2)th rising edge after the first edge that samples the new value (2 synchroniser edges plus DEBOUNCE_LIMIT stable edges).
- DEBOUNCE_LIMIT=1: o_Debounced follows s with 1 cycle delay; no filtering.
- Edge strobes: registered; o_Rise[n]/o_Fall[n] are high for exactly the one cycle after o_Debounced[n] changes, i.e. asserted in the cycle where the new level is first visible. Rise and fall are never both high on one channel.
- Toggle: o_Toggle[n] inverts on the same edge that sets o_Fall[n] (TOGGLE_ON_RELEASE=1) or o_Rise[n] (TOGGLE_ON_RELEASE=0). No other event changes it.
- Channels are fully independent. Simultaneous events on several channels are all handled in the same cycle, with no arbitration.
- Input pulse shorter than DEBOUNCE_LIMIT stable cycles produces no output activity.
- RESET_LEVEL=1 with input held high after reset: no strobes and no toggle are produced.

Test Plan:
1. NUM_CH=4, LIMIT=4, RESET_LEVEL=0; assert reset, hold ch0 at 1 during reset -> all outputs 0 during reset. After release, o_Debounced[0]=1 exactly 6 edges later, with o_Rise[0] high for 1 cycle.
2. Ch1 bounce 1,0,1,1,0,1 at one sample per clock, then steady 1 -> o_Debounced[1] rises only after 4 consecutive stable s-cycles. Exactly one o_Rise[1] pulse; no o_Fall[1].
3. Ch2 press-then-release (1 for 20 cycles, then 0 for 20 cycles), TOGGLE_ON_RELEASE=1 -> o_Toggle[2] stays 0 through the rise and becomes 1 in the same cycle as o_Fall[2]. Repeat the press -> o_Toggle[2] returns to 0.
4. Ch3 3-cycle pulse with LIMIT=4 -> no change on o_Debounced[3], o_Rise[3], o_Fall[3] or o_Toggle[3].
5. All 4 channels stepped 0->1 on the same clock -> o_Rise = 4'hF for a single cycle, then 4'h0.
6. Assert i_Rst_L low mid-count (count=2) on ch0 and again with o_Toggle[0]=1 -> counter, level and toggle all return to reset values immediately, asynchronously, without waiting for a clock edge.
